// File: rtl/icache_fetch.sv
// ---------------------------------------------------------------------------
// icache_fetch
//   Direct-mapped, read-only instruction cache in front of the fetch stage.
//   Each entry holds the 4-byte little-endian window that starts at a
//   halfword-aligned PC. Overlapping windows live in different entries.
//   A hit returns in the same cycle. A miss fills the window one byte at a
//   time through the shared memory arbiter.
//
// Ports
//   clk          system clock
//   rst_in       asynchronous active-high reset
//   rdy_in       global ready; low freezes all state and forces inst_rdy=0
//   pc_in        fetch PC (bit 0 ignored)
//   fetch_en     fetch stage wants an instruction this cycle
//   flush        ROB flush; aborts a fill in progress
//   inst_rdy     inst_out is valid for pc_in this cycle
//   inst_out     {M[pc+3],M[pc+2],M[pc+1],M[pc]}
//   mem_req      byte read request to the arbiter
//   mem_addr     byte address of the request
//   mem_gnt      arbiter accepts the request this cycle
//   mem_din      returned byte
//   mem_din_vld  mem_din valid (one per grant, in order, latency >= 1)
//   dbg_state    current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 DRAIN)
//
// Memory handshake: a request transfers on a cycle where mem_req and
// mem_gnt are both high while rdy_in is high; exactly one mem_din_vld pulse
// follows each transfer, at least one cycle later. A grant seen while
// rdy_in is low is ignored.
// ---------------------------------------------------------------------------
module icache_fetch #(
  parameter int IDX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] pc_in,
  input  logic        fetch_en,
  input  logic        flush,
  output logic        inst_rdy,
  output logic [31:0] inst_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_din,
  input  logic        mem_din_vld,
  output logic [1:0]  dbg_state
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 31 - IDX_BITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t               r_state;
  logic [1:0]           r_k;
  logic                 r_pending;
  logic [31:0]          r_miss_pc;
  logic [23:0]          r_buf;
  logic [ENTRIES-1:0]   r_valid;
  logic [TAG_W-1:0]     r_tag  [ENTRIES];
  logic [31:0]          r_data [ENTRIES];

  state_t               w_state_nxt;
  logic [1:0]           w_k_nxt;
  logic                 w_pend_nxt;
  logic [31:0]          w_miss_nxt;
  logic [23:0]          w_buf_nxt;
  logic                 w_fill_we;
  logic [IDX_BITS-1:0]  w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic [IDX_BITS-1:0]  w_fill_idx;
  logic                 w_hit;

  assign w_idx      = pc_in[IDX_BITS:1];
  assign w_tag      = pc_in[31:IDX_BITS+1];
  assign w_fill_idx = r_miss_pc[IDX_BITS:1];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  assign inst_rdy  = rdy_in && (r_state == S_IDLE) && fetch_en && !flush && w_hit;
  assign inst_out  = r_data[w_idx];
  assign mem_req   = (r_state == S_REQ) && rdy_in;
  // Wraps naturally at 2^32, so a window at 0xFFFFFFFE reads 0xFFFFFFFE..0x1.
  assign mem_addr  = r_miss_pc + {30'd0, r_k};
  assign dbg_state = r_state;

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_pend_nxt  = r_pending;
    w_miss_nxt  = r_miss_pc;
    w_buf_nxt   = r_buf;
    w_fill_we   = 1'b0;
    if (rdy_in) begin
      case (r_state)
        S_IDLE: begin
          if (fetch_en && !flush && !w_hit) begin
            // Masking keeps the whole PC bus read; bit 0 is never used.
            w_miss_nxt  = pc_in & 32'hFFFF_FFFE;
            w_k_nxt     = 2'd0;
            w_state_nxt = S_REQ;
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            // A grant coincident with flush still owes us one response.
            w_pend_nxt  = 1'b1;
            w_state_nxt = flush ? S_DRAIN : S_WAIT;
          end else if (flush) begin
            w_state_nxt = S_IDLE;
          end
        end
        S_WAIT: begin
          if (mem_din_vld && r_pending) begin
            w_pend_nxt = 1'b0;
            if (flush) begin
              w_state_nxt = S_IDLE;
            end else if (r_k == 2'd3) begin
              w_fill_we   = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              case (r_k)
                2'd0:    w_buf_nxt[7:0]   = mem_din;
                2'd1:    w_buf_nxt[15:8]  = mem_din;
                default: w_buf_nxt[23:16] = mem_din;
              endcase
              w_k_nxt     = r_k + 2'd1;
              w_state_nxt = S_REQ;
            end
          end else if (flush) begin
            w_state_nxt = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (mem_din_vld) begin
            w_pend_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= S_IDLE;
      r_k       <= 2'd0;
      r_pending <= 1'b0;
      r_miss_pc <= 32'd0;
      r_buf     <= 24'd0;
      r_valid   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_k       <= w_k_nxt;
      r_pending <= w_pend_nxt;
      r_miss_pc <= w_miss_nxt;
      r_buf     <= w_buf_nxt;
      if (w_fill_we) r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Tag and data need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_data[w_fill_idx] <= {mem_din, r_buf};
      r_tag[w_fill_idx]  <= r_miss_pc[31:IDX_BITS+1];
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// ---------------------------------------------------------------------------
// tb_icache_fetch
//   Directed bench for icache_fetch (IDX_BITS=6). Inputs change just after
//   the falling edge; outputs are sampled 1 ns later, well clear of the
//   rising edge. Memory contents come from mem_byte().
// ---------------------------------------------------------------------------
module tb_icache_fetch;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  always #5 clk = ~clk;

  logic        rdy_in = 1'b1;
  logic [31:0] pc_in = 32'd0;
  logic        fetch_en = 1'b0;
  logic        flush = 1'b0;
  logic        inst_rdy;
  logic [31:0] inst_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic [7:0]  mem_din = 8'd0;
  logic        mem_din_vld = 1'b0;
  logic [1:0]  dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  icache_fetch #(.IDX_BITS(6)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .pc_in(pc_in),
    .fetch_en(fetch_en), .flush(flush), .inst_rdy(inst_rdy),
    .inst_out(inst_out), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_din(mem_din), .mem_din_vld(mem_din_vld),
    .dbg_state(dbg_state)
  );

  // memory model
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 8'h13;
      32'h0000_1001: return 8'h05;
      32'h0000_1002: return 8'h00;
      32'h0000_1003: return 8'h00;
      default:       return a[7:0] ^ a[15:8] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] exp_win(input logic [31:0] pc);
    return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2),
            mem_byte(pc + 32'd1), mem_byte(pc)};
  endfunction

  // checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_miss(input logic [31:0] pc);
    pc_in = pc;
    fetch_en = 1'b1;
    #1;
    chk("miss_inst_rdy", inst_rdy, 0);
    tick();
    #1;
    chk("miss_to_req", dbg_state, S_REQ);
  endtask

  task automatic grant_byte(input logic [31:0] a);
    chk("req_mem_req", mem_req, 1);
    chk("req_mem_addr", mem_addr, a);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #1;
    chk("gnt_to_wait", dbg_state, S_WAIT);
    chk("wait_mem_req", mem_req, 0);
  endtask

  task automatic resp_byte(input logic [31:0] a, input int lat);
    repeat (lat - 1) tick();
    mem_din = mem_byte(a);
    mem_din_vld = 1'b1;
    tick();
    mem_din_vld = 1'b0;
    #1;
  endtask

  task automatic do_fill(input logic [31:0] pc);
    for (int i = 0; i < 4; i++) begin
      grant_byte(pc + i);
      resp_byte(pc + i, 1);
    end
    chk("fill_idle", dbg_state, S_IDLE);
    chk("fill_inst_rdy", inst_rdy, 1);
    chk("fill_inst_out", inst_out, exp_win(pc));
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_inst_rdy", inst_rdy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_state", dbg_state, S_IDLE);
    @(negedge clk);
    rst_in = 1'b0;

    // cold miss at 0x1000, then 0-cycle hit
    start_miss(32'h0000_1000);
    do_fill(32'h0000_1000);
    chk("cold_inst_out", inst_out, 32'h0000_0513);
    tick();
    #1;
    chk("repeat_hit", inst_rdy, 1);
    chk("repeat_mem_req", mem_req, 0);

    // rdy_in low masks a hit
    rdy_in = 1'b0;
    #1;
    chk("rdy_low_hit", inst_rdy, 0);
    rdy_in = 1'b1;

    // flush on a hit cycle masks it
    flush = 1'b1;
    #1;
    chk("flush_hit", inst_rdy, 0);
    flush = 1'b0;

    // halfword-aligned window is a distinct entry
    start_miss(32'h0000_1002);
    do_fill(32'h0000_1002);
    chk("half_lo16", {16'd0, inst_out[15:0]}, 32'h0000_0000);

    // conflict eviction: 0x1080 shares index 0 with 0x1000
    start_miss(32'h0000_1080);
    do_fill(32'h0000_1080);
    pc_in = 32'h0000_1000;
    #1;
    chk("evicted_1000", inst_rdy, 0);
    fetch_en = 1'b0;
    tick();
    #1;
    chk("no_fetch_idle", dbg_state, S_IDLE);

    // flush after byte 1 is granted, response 3 cycles late
    start_miss(32'h0000_2000);
    grant_byte(32'h0000_2000);
    resp_byte(32'h0000_2000, 1);
    grant_byte(32'h0000_2001);
    flush = 1'b1;
    #1;
    chk("flush_wait_rdy", inst_rdy, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("drain_state", dbg_state, S_DRAIN);
    chk("drain_mem_req", mem_req, 0);
    tick();
    #1;
    chk("drain_hold", dbg_state, S_DRAIN);
    mem_din = 8'hEE;
    mem_din_vld = 1'b1;
    tick();
    mem_din_vld = 1'b0;
    #1;
    chk("drain_to_idle", dbg_state, S_IDLE);
    chk("aborted_no_hit", inst_rdy, 0);
    tick();
    #1;
    chk("restart_byte0", mem_addr, 32'h0000_2000);
    do_fill(32'h0000_2000);

    // wrap-around window
    start_miss(32'hFFFF_FFFE);
    do_fill(32'hFFFF_FFFE);

    // grant coincident with flush: drain exactly one response
    start_miss(32'h0000_3000);
    chk("gf_mem_req", mem_req, 1);
    mem_gnt = 1'b1;
    flush = 1'b1;
    tick();
    mem_gnt = 1'b0;
    flush = 1'b0;
    #1;
    chk("gf_drain", dbg_state, S_DRAIN);
    chk("gf_mem_req_lo", mem_req, 0);
    tick();
    #1;
    chk("gf_drain_hold", dbg_state, S_DRAIN);
    mem_din_vld = 1'b1;
    tick();
    mem_din_vld = 1'b0;
    #1;
    chk("gf_idle", dbg_state, S_IDLE);
    chk("gf_no_hit", inst_rdy, 0);

    // flush in REQ without a grant returns to IDLE
    tick();
    #1;
    chk("fr_req", dbg_state, S_REQ);
    flush = 1'b1;
    fetch_en = 1'b0;
    #1;
    chk("fr_mem_req", mem_req, 1);
    tick();
    flush = 1'b0;
    #1;
    chk("fr_idle", dbg_state, S_IDLE);
    chk("fr_mem_req_lo", mem_req, 0);

    // rdy_in low for 5 cycles in WAIT with grant pulsing
    start_miss(32'h0000_4000);
    grant_byte(32'h0000_4000);
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_gnt = i[0];
      #1;
      chk("frz_inst_rdy", inst_rdy, 0);
      chk("frz_state", dbg_state, S_WAIT);
      chk("frz_mem_addr", mem_addr, 32'h0000_4000);
      tick();
    end
    mem_gnt = 1'b0;
    rdy_in = 1'b1;
    resp_byte(32'h0000_4000, 1);
    chk("frz_resume_req", dbg_state, S_REQ);
    for (int i = 1; i < 4; i++) begin
      grant_byte(32'h0000_4000 + i);
      resp_byte(32'h0000_4000 + i, 1);
    end
    chk("frz_hit", inst_rdy, 1);
    chk("frz_inst_out", inst_out, exp_win(32'h0000_4000));

    // asynchronous reset mid-fill
    start_miss(32'h0000_5000);
    chk("ar_mem_req", mem_req, 1);
    #2;
    rst_in = 1'b1;
    #1;
    chk("ar_mem_req_lo", mem_req, 0);
    chk("ar_state", dbg_state, S_IDLE);
    pc_in = 32'h0000_4000;
    #1;
    chk("ar_inval_4000", inst_rdy, 0);
    pc_in = 32'h0000_1002;
    #1;
    chk("ar_inval_1002", inst_rdy, 0);
    tick();
    rst_in = 1'b0;
    fetch_en = 1'b0;
    #1;
    chk("ar_after_state", dbg_state, S_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
